// File: rtl/grid_scanout_if.sv
// Bundle between the game FSM / board pins and grid_scanout.
// Request rule: frame_start_i is taken on a clk edge only while busy_o is low; it is never queued.
interface grid_scanout_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic                 frame_start_i;
  logic [ROWS*COLS-1:0] display_array_i;
  logic                 busy_o;
  logic                 frame_done_o;
  logic                 sclk_o;
  logic                 sdata_o;
  logic                 latch_o;
  logic [4:0]           row_sel_o;
  logic [1:0]           scan_state;

  modport master (
    output frame_start_i, display_array_i,
    input  busy_o, frame_done_o, sclk_o, sdata_o, latch_o, row_sel_o, scan_state
  );

  modport slave (
    input  frame_start_i, display_array_i,
    output busy_o, frame_done_o, sclk_o, sdata_o, latch_o, row_sel_o, scan_state
  );
endinterface

// File: rtl/grid_scanout.sv
// Serialises a snapshot of the ROWS x COLS playfield to a shift-register LED matrix, row by row.
// Define GRID_SCANOUT_PARITY_EN to append an odd-parity bit to every row before it is latched.
module grid_scanout #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CLK_DIV = 4
) (
  input logic           clk,
  input logic           reset_n,
  grid_scanout_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int IDX_W = $clog2(ROWS * COLS);
`ifdef GRID_SCANOUT_PARITY_EN
  localparam int NBITS = COLS + 1;
`else
  localparam int NBITS = COLS;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] snap_q;
  logic [4:0]           row_q;
  logic [4:0]           row_sel_q;
  logic [CNT_W-1:0]     bit_q;
  logic [DIV_W-1:0]     div_q;
  logic                 phase_q;  // 0: sclk low half, 1: sclk high half
  logic                 div_last, bit_last, row_last;
  logic [CNT_W-1:0]     col;
  logic [IDX_W-1:0]     row_base, bit_idx;
  logic                 data_bit;

  assign div_last = div_q == DIV_W'(CLK_DIV - 1);
  assign bit_last = bit_q == CNT_W'(NBITS - 1);
  assign row_last = row_q == 5'(ROWS - 1);
  assign col      = CNT_W'(COLS - 1) - bit_q;
  assign row_base = IDX_W'(row_q) * IDX_W'(COLS);
  assign bit_idx  = row_base + IDX_W'(col);

`ifdef GRID_SCANOUT_PARITY_EN
  // The slot after col 0 carries XNOR of the row, i.e. odd parity over data plus this bit.
  always_comb begin
    data_bit = snap_q[bit_idx];
    if (bit_q == CNT_W'(COLS)) data_bit = ~^snap_q[row_base +: COLS];
  end
`else
  assign data_bit = snap_q[bit_idx];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.frame_start_i) state_d = SHIFT;
      SHIFT:   if (div_last && phase_q && bit_last) state_d = LATCH;
      LATCH:   if (div_last) state_d = row_last ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q    <= '0;
      row_q     <= '0;
      row_sel_q <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.frame_start_i) begin
            snap_q  <= bus.display_array_i;
            row_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        SHIFT: begin
          div_q <= div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            phase_q <= ~phase_q;
            if (phase_q) bit_q <= bit_last ? '0 : bit_q + 1'b1;
          end
        end
        LATCH: begin
          div_q     <= div_last ? '0 : div_q + 1'b1;
          row_sel_q <= row_q;
          if (div_last && !row_last) row_q <= row_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o       = state_q != IDLE;
  assign bus.frame_done_o = state_q == DONE;
  assign bus.sclk_o       = (state_q == SHIFT) && phase_q;
  assign bus.sdata_o      = (state_q == SHIFT) && data_bit;
  assign bus.latch_o      = state_q == LATCH;
  // Live row during LATCH; otherwise the last row that was latched.
  assign bus.row_sel_o    = (state_q == LATCH) ? row_q : row_sel_q;
  assign bus.scan_state   = state_q;
endmodule

// File: tb/tb_grid_scanout.sv
// Bench for grid_scanout: serial-bit and row scoreboard, frame timing, request filtering, CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_grid_scanout;
  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int CLK_DIV = 4;
  localparam int N       = ROWS * COLS;
`ifdef GRID_SCANOUT_PARITY_EN
  localparam int NBITS = COLS + 1;
`else
  localparam int NBITS = COLS;
`endif
  localparam int FRAME_LEN  = ROWS * (2 * CLK_DIV * NBITS + CLK_DIV) + 1;
  localparam int FRAME_LEN1 = ROWS * (2 * NBITS + 1) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  grid_scanout_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  grid_scanout_if #(.ROWS(ROWS), .COLS(COLS)) bus1 ();

  grid_scanout #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  grid_scanout #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int total = 0;
  int bad = 0;
  logic [0:0] exp_q[$];
  logic [4:0] row_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor for the CLK_DIV=4 instance
  logic busy_p = 0, sclk_p = 0, latch_p = 0;
  int busy_len = 0, rises = 0, high_cyc = 0, latches = 0, latch_len = 0, dones = 0;
  int sclk_total = 0, busy_starts = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy_p = 0; sclk_p = 0; latch_p = 0;
      busy_len = 0; rises = 0; high_cyc = 0; latches = 0; latch_len = 0; dones = 0;
    end else begin
      if (bus.sclk_o && !sclk_p) begin
        rises++;
        sclk_total++;
        check("bit_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sdata", bus.sdata_o, exp_q.pop_front());
      end
      if (bus.sclk_o) high_cyc++;
      if (bus.latch_o) begin
        latch_len++;
        if (!latch_p) begin
          latches++;
          check("latch_sdata", bus.sdata_o, 0);
          check("row_avail", row_q.size() > 0, 1);
          if (row_q.size() > 0) check("row_sel", bus.row_sel_o, row_q.pop_front());
        end
      end else if (latch_p) begin
        check("latch_len", latch_len, CLK_DIV);
        latch_len = 0;
      end
      if (bus.frame_done_o) dones++;
      if (bus.busy_o) begin
        if (!busy_p) busy_starts++;
        busy_len++;
      end else if (busy_p) begin
        check("busy_len", busy_len, FRAME_LEN);
        check("sclk_rises", rises, ROWS * NBITS);
        check("sclk_high", high_cyc, ROWS * NBITS * CLK_DIV);
        check("latch_pulses", latches, ROWS);
        check("done_pulses", dones, 1);
        busy_len = 0; rises = 0; high_cyc = 0; latches = 0; dones = 0;
      end
      busy_p  = bus.busy_o;
      sclk_p  = bus.sclk_o;
      latch_p = bus.latch_o;
    end
  end

  // monitor for the CLK_DIV=1 instance
  logic busy1_p = 0, sclk1_p = 0;
  int busy1_len = 0, rises1 = 0, high1 = 0, frames1 = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy1_p = 0; sclk1_p = 0; busy1_len = 0; rises1 = 0; high1 = 0;
    end else begin
      if (bus1.sclk_o && !sclk1_p) rises1++;
      if (bus1.sclk_o) high1++;
      if (bus1.busy_o) busy1_len++;
      else if (busy1_p) begin
        check("div1_busy_len", busy1_len, FRAME_LEN1);
        check("div1_rises", rises1, ROWS * NBITS);
        check("div1_high", high1, ROWS * NBITS);
        frames1++;
        busy1_len = 0; rises1 = 0; high1 = 0;
      end
      busy1_p = bus1.busy_o;
      sclk1_p = bus1.sclk_o;
    end
  end

  // driver tasks
  task automatic push_frame(input logic [N-1:0] img);
    int ones;
    for (int r = 0; r < ROWS; r++) begin
      ones = 0;
      for (int c = COLS - 1; c >= 0; c--) begin
        exp_q.push_back(img[r*COLS+c]);
        ones += int'(img[r*COLS+c]);
      end
`ifdef GRID_SCANOUT_PARITY_EN
      exp_q.push_back((ones % 2) == 0);
`endif
      row_q.push_back(5'(r));
    end
  endtask

  task automatic start_frame(input logic [N-1:0] img);
    push_frame(img);
    @(posedge clk); #1;
    bus.display_array_i = img;
    bus.frame_start_i   = 1'b1;
    @(posedge clk); #1;
    bus.frame_start_i   = 1'b0;
  endtask

  task automatic wait_done_pulse();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.frame_done_o && n < FRAME_LEN + 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.frame_done_o, 1);
  endtask

  task automatic wait_done();
    wait_done_pulse();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] rand_img();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  logic [N-1:0] img;
  int t0, s0, f0, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start_i    = 1'b0;
    bus.display_array_i  = '0;
    bus1.frame_start_i   = 1'b0;
    bus1.display_array_i = '0;

    // reset state
    #1;
    check("rst_outs", {bus.busy_o, bus.frame_done_o, bus.sclk_o, bus.sdata_o, bus.latch_o, bus.row_sel_o}, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    t0 = sclk_total; s0 = busy_starts;
    repeat (40) @(posedge clk);
    #1;
    check("idle_sclk", sclk_total - t0, 0);
    check("idle_frames", busy_starts - s0, 0);

    // asynchronous reset in the middle of SHIFT
    start_frame(rand_img());
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outs", {bus.busy_o, bus.frame_done_o, bus.sclk_o, bus.sdata_o, bus.latch_o, bus.row_sel_o}, 0);
    check("midrst_state", bus.scan_state, 0);
    exp_q.delete();
    row_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    t0 = sclk_total; s0 = busy_starts;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_sclk", sclk_total - t0, 0);
    check("post_rst_busy", bus.busy_o, 0);

    // single-bit image
    img = '0;
    img[0] = 1'b1;
    start_frame(img);
    wait_done();
    @(posedge clk); #1;
    check("single_q_empty", exp_q.size(), 0);

    // snapshot isolation: checkerboard, input swapped to all-ones mid-frame
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) img[r*COLS+c] = 1'((r + c) % 2);
    start_frame(img);
    repeat (99) @(posedge clk);
    #1 bus.display_array_i = '1;
    wait_done();
    @(posedge clk); #1;
    check("snap_q_empty", exp_q.size(), 0);

    // row 3 = 0b0000000111, others zero
    img = '0;
    img[30] = 1'b1; img[31] = 1'b1; img[32] = 1'b1;
    start_frame(img);
    wait_done();

    // frame_start held high: back-to-back frames, re-accepted one idle cycle after DONE
    img = rand_img();
    push_frame(img);
    push_frame(img);
    @(posedge clk); #1;
    bus.display_array_i = img;
    bus.frame_start_i   = 1'b1;
    wait_done_pulse();
    n = 0;
    @(negedge clk);
    n++;
    while (!bus.busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reaccept_gap", n, 2);
    bus.frame_start_i = 1'b0;
    wait_done();
    @(posedge clk); #1;
    check("held_q_empty", exp_q.size(), 0);

    // a pulse confined to the DONE cycle starts nothing
    start_frame(rand_img());
    wait_done_pulse();
    bus.frame_start_i = 1'b1;
    @(posedge clk); #1;
    bus.frame_start_i = 1'b0;
    s0 = busy_starts;
    repeat (20) @(posedge clk);
    #1;
    check("done_pulse_frames", busy_starts - s0, 0);
    check("done_pulse_busy", bus.busy_o, 0);

    // random images
    for (int k = 0; k < 2; k++) begin
      start_frame(rand_img());
      wait_done();
    end

    // CLK_DIV=1 instance
    f0 = frames1;
    @(posedge clk); #1;
    bus1.display_array_i = rand_img();
    bus1.frame_start_i   = 1'b1;
    @(posedge clk); #1;
    bus1.frame_start_i   = 1'b0;
    n = 0;
    while (frames1 == f0 && n < FRAME_LEN1 + 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("div1_frames", frames1 - f0, 1);

    repeat (2) @(posedge clk);
    #1;
    check("final_q", exp_q.size() + row_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
